// File: rtl/avalon_tx_fifo_port.sv
// avalon_tx_fifo_port: Avalon-MM write buffer feeding a TX stream.
// CPU writes land in a flop FIFO and drain over valid/ready.
module avalon_tx_fifo_port #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              irq
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = AW + 1;

   typedef logic [AW-1:0] ptr_t;
   typedef logic [LW-1:0] lvl_t;

   localparam lvl_t FULL_LVL = lvl_t'(DEPTH);

   localparam logic [1:0] A_DATA = 2'd0;
   localparam logic [1:0] A_STAT = 2'd1;
   localparam logic [1:0] A_CTRL = 2'd2;
   localparam logic [1:0] A_THR  = 2'd3;

   // storage, not reset
   logic [DATA_W-1:0] mem_q [DEPTH];

   ptr_t       rd_ptr_q, rd_ptr_d;
   ptr_t       wr_ptr_q, wr_ptr_d;
   lvl_t       level_q, level_d;
   logic       ovf_q, ovf_d;
   logic       en_q, en_d;
   logic       ien_q, ien_d;
   logic       irq_q, irq_d;
   logic [7:0] thr_q, thr_d;

   logic       wr;
   logic       wr_data;
   logic       wr_stat;
   logic       wr_ctrl;
   logic       wr_thr;
   logic       flush;
   logic       pop;
   logic       push;
   logic       drop;
   logic       empty;
   logic       full;
   logic [7:0] level8;
   logic       unused_wd;

   assign unused_wd = ^writedata;

   // bus write decode
   assign wr      = chipselect & ~write_n;
   assign wr_data = wr & (address == A_DATA);
   assign wr_stat = wr & (address == A_STAT);
   assign wr_ctrl = wr & (address == A_CTRL);
   assign wr_thr  = wr & (address == A_THR);
   assign flush   = wr_ctrl & writedata[2];

   // fill status
   assign empty  = (level_q == '0);
   assign full   = (level_q == FULL_LVL);
   assign level8 = 8'(level_q);

   // stream handshake; head held while disabled
   assign out_valid = en_q & ~empty;
   assign pop       = out_valid & out_ready;
   assign out_data  = out_valid ? mem_q[rd_ptr_q]
                                : '0;

   // a full FIFO still accepts when the head leaves this cycle;
   // flush discards the write and never flags overflow
   assign push = wr_data & (~full | pop) & ~flush;
   assign drop = wr_data & full & ~pop & ~flush;

   assign irq = irq_q;

   // pointer and level next state
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
         end
         if (push & ~pop) begin
            level_d = level_q + lvl_t'(1);
         end else if (pop & ~push) begin
            level_d = level_q - lvl_t'(1);
         end
      end
   end

   // control registers, sticky overflow and irq next state
   always_comb begin
      en_d  = en_q;
      ien_d = ien_q;
      thr_d = thr_q;
      ovf_d = ovf_q;
      if (wr_ctrl) begin
         en_d  = writedata[0];
         ien_d = writedata[1];
      end
      if (wr_thr) begin
         thr_d = writedata[7:0];
      end
      if (wr_stat & writedata[10]) begin
         ovf_d = 1'b0;
      end
      // a new overflow beats a same-cycle clear
      if (drop) begin
         ovf_d = 1'b1;
      end
      irq_d = ien_q & (level8 <= thr_q);
   end

   // state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         en_q     <= 1'b1;
         ien_q    <= 1'b0;
         thr_q    <= '0;
         irq_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         en_q     <= en_d;
         ien_q    <= ien_d;
         thr_q    <= thr_d;
         irq_q    <= irq_d;
      end
   end

   // entry storage write
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= writedata[DATA_W-1:0];
      end
   end

   // combinational read mux
   always_comb begin
      readdata = '0;
      unique case (address)
         A_DATA: readdata = 32'(out_data);
         A_STAT: readdata = {21'd0, ovf_q, full,
                             empty, level8};
         A_CTRL: readdata = {30'd0, ien_q, en_q};
         A_THR:  readdata = {24'd0, thr_q};
         default: readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_avalon_tx_fifo_port.sv
// tb_avalon_tx_fifo_port: scoreboard bench for the TX FIFO port.
// Queue-based reference model, randomized plus directed traffic.
module tb_avalon_tx_fifo_port;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        irq;

   logic [1:0]  b_addr;
   logic        b_cs;
   logic        b_wn;
   logic [31:0] b_wd;
   logic [31:0] b_rdata;
   logic [11:0] b_data;
   logic        b_valid;
   logic        b_ready;
   logic        b_irq;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: queue contents are the FIFO contents
   logic [7:0]  sbq[$];
   logic [11:0] bq[$];
   bit          m_en  = 1'b1;
   bit          m_ien = 1'b0;
   bit          m_ovf = 1'b0;
   bit          m_irq = 1'b0;
   int          m_thr = 0;

   always #10 clk = ~clk;

   avalon_tx_fifo_port #(.DATA_W(8), .DEPTH(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata),
      .readdata(readdata), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .irq(irq)
   );

   avalon_tx_fifo_port #(.DATA_W(12), .DEPTH(4)) dut_b (
      .clk(clk), .reset_n(reset_n),
      .address(b_addr), .chipselect(b_cs),
      .write_n(b_wn), .writedata(b_wd),
      .readdata(b_rdata), .out_data(b_data),
      .out_valid(b_valid), .out_ready(b_ready),
      .irq(b_irq)
   );

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   // monitors: every handshake pops the expected head
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            chk("pop_underflow", {24'd0, out_data}, 32'hFFFF_FFFF);
         end else begin
            chk("pop_data", {24'd0, out_data}, {24'd0, sbq.pop_front()});
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n && b_valid && b_ready) begin
         if (bq.size() == 0) begin
            chk("b_pop_underflow", {20'd0, b_data}, 32'hFFFF_FFFF);
         end else begin
            chk("b_pop_data", {20'd0, b_data}, {20'd0, bq.pop_front()});
         end
      end
   end

   task automatic check_state();
      int n;
      bit v;
      logic [31:0] st;
      n  = sbq.size();
      v  = m_en && (n != 0);
      st = {21'd0, m_ovf, (n == 16), (n == 0), 8'(n)};
      chk("irq", {31'd0, irq}, {31'd0, m_irq});
      chk("out_valid", {31'd0, out_valid}, {31'd0, v});
      if (v) chk("out_head", {24'd0, out_data}, {24'd0, sbq[0]});
      else   chk("out_idle", {24'd0, out_data}, 32'd0);
      chipselect = 1'b0;
      write_n    = 1'b1;
      address = 2'd0; #1;
      chk("rd_data", readdata, v ? {24'd0, sbq[0]} : 32'd0);
      address = 2'd1; #1;
      chk("status", readdata, st);
      address = 2'd2; #1;
      chk("control", readdata, {30'd0, m_ien, m_en});
      address = 2'd3; #1;
      chk("threshold", readdata, 32'(m_thr));
   endtask

   // one bus cycle on the main port, model updated for the coming edge
   task automatic step(input bit cs_i, input logic [1:0] a_i,
                       input logic [31:0] wd_i, input bit rdy_i);
      bit fl;
      bit pop;
      int n;
      @(posedge clk); #1;
      check_state();
      n  = sbq.size();
      fl = cs_i && (a_i == 2'd2) && wd_i[2];
      out_ready  = fl ? 1'b0 : rdy_i;
      pop        = m_en && (n != 0) && out_ready;
      m_irq      = m_ien && (n <= m_thr);
      address    = a_i;
      chipselect = cs_i;
      write_n    = ~cs_i;
      writedata  = wd_i;
      if (cs_i) begin
         case (a_i)
            2'd0: begin
               if (n < 16 || pop) sbq.push_back(wd_i[7:0]);
               else m_ovf = 1'b1;
            end
            2'd1: if (wd_i[10]) m_ovf = 1'b0;
            2'd2: begin
               m_en  = wd_i[0];
               m_ien = wd_i[1];
               if (fl) sbq.delete();
            end
            default: m_thr = int'(wd_i[7:0]);
         endcase
      end
   endtask

   task automatic idle(input int k, input bit r);
      for (int i = 0; i < k; i++) step(1'b0, 2'd1, 32'd0, r);
   endtask

   task automatic bstep(input bit w, input logic [31:0] wd, input bit r);
      int n;
      bit pop;
      @(posedge clk); #1;
      n = bq.size();
      chk("b_valid", {31'd0, b_valid}, {31'd0, (n != 0)});
      if (n != 0) chk("b_head", {20'd0, b_data}, {20'd0, bq[0]});
      else        chk("b_idle", {20'd0, b_data}, 32'd0);
      pop     = (n != 0) && r;
      b_ready = r;
      b_cs    = w;
      b_wn    = ~w;
      b_addr  = 2'd0;
      b_wd    = wd;
      if (w && (n < 4 || pop)) bq.push_back(wd[11:0]);
   endtask

   // asynchronous reset mid-cycle; outputs must clear at once
   task automatic do_reset();
      @(posedge clk); #3;
      reset_n = 1'b0;
      #1;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data", {24'd0, out_data}, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
      chk("rst_b_irq", {31'd0, b_irq}, 32'd0);
      chipselect = 1'b0; write_n = 1'b1; out_ready = 1'b0;
      b_cs = 1'b0; b_wn = 1'b1; b_ready = 1'b0;
      address = 2'd1; b_addr = 2'd1;
      #1;
      chk("rst_status", readdata, 32'h100);
      chk("rst_b_status", b_rdata, 32'h100);
      address = 2'd2; #1;
      chk("rst_control", readdata, 32'h1);
      sbq.delete(); bq.delete();
      m_en = 1'b1; m_ien = 1'b0; m_ovf = 1'b0;
      m_irq = 1'b0; m_thr = 0;
      @(posedge clk); #3;
      reset_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      int rdy_pct;
      address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; out_ready = 1'b0;
      b_addr = 2'd0; b_cs = 1'b0; b_wn = 1'b1;
      b_wd = '0; b_ready = 1'b0;

      do_reset();

      // three characters streamed straight through
      step(1'b1, 2'd0, 32'h41, 1'b1);
      step(1'b1, 2'd0, 32'h42, 1'b1);
      step(1'b1, 2'd0, 32'h43, 1'b1);
      idle(3, 1'b1);

      // overfill, drain, clear overflow
      for (int i = 0; i < 17; i++) step(1'b1, 2'd0, 32'(8'h10 + i), 1'b0);
      idle(2, 1'b0);
      idle(18, 1'b1);
      step(1'b1, 2'd1, 32'h400, 1'b0);
      idle(1, 1'b0);

      // full FIFO with simultaneous push and pop
      for (int i = 0; i < 16; i++) step(1'b1, 2'd0, 32'(8'h80 + i), 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 32'h5A, 1'b1);
      idle(26, 1'b1);

      // drain enable and flush
      step(1'b1, 2'd2, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 32'(8'hC0 + i), 1'b1);
      idle(3, 1'b1);
      step(1'b1, 2'd2, 32'h1, 1'b1);
      idle(4, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 2'd0, 32'(8'hD0 + i), 1'b0);
      step(1'b1, 2'd2, 32'h5, 1'b1);
      idle(2, 1'b1);

      // low-water interrupt
      step(1'b1, 2'd3, 32'h2, 1'b0);
      step(1'b1, 2'd2, 32'h3, 1'b0);
      idle(2, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 32'(8'hE0 + i), 1'b0);
      idle(2, 1'b0);
      idle(2, 1'b1);
      idle(3, 1'b0);
      idle(4, 1'b1);

      // randomized traffic with a mid-stream reset
      for (int c = 0; c < 600; c++) begin
         if (c % 100 == 0) rdy_pct = $urandom_range(10, 95);
         if (c == 300) begin
            for (int i = 0; i < 3; i++) step(1'b1, 2'd0, $urandom(), 1'b0);
            do_reset();
         end
         r = $urandom_range(0, 99);
         if (r < 55) begin
            step(1'b1, 2'd0, $urandom(),
                 $urandom_range(0, 99) < rdy_pct);
         end else if (r < 62) begin
            step(1'b1, 2'd1, $urandom() & 32'hFFFF_F000 |
                 (32'($urandom_range(0, 1)) << 10),
                 $urandom_range(0, 99) < rdy_pct);
         end else if (r < 70) begin
            step(1'b1, 2'd2,
                 ($urandom() & 32'hFFFF_FFF8) |
                 (32'($urandom_range(0, 9) == 0) << 2) |
                 (32'($urandom_range(0, 1)) << 1) |
                 32'($urandom_range(0, 3) != 0),
                 $urandom_range(0, 99) < rdy_pct);
         end else if (r < 75) begin
            step(1'b1, 2'd3,
                 ($urandom() & 32'hFFFF_FF00) |
                 32'($urandom_range(0, 20)),
                 $urandom_range(0, 99) < rdy_pct);
         end else begin
            idle(1, $urandom_range(0, 99) < rdy_pct);
         end
      end
      step(1'b1, 2'd2, 32'h1, 1'b1);
      idle(20, 1'b1);

      // narrow, shallow instance: truncation and pointer wrap
      bstep(1'b1, 32'h00FF_FABC, 1'b0);
      bstep(1'b0, 32'd0, 1'b0);
      bstep(1'b0, 32'd0, 1'b1);
      for (int i = 0; i < 12; i++) bstep(1'b1, 32'(i * 32'h111), 1'b1);
      for (int i = 0; i < 60; i++) begin
         bstep($urandom_range(0, 1) == 1, $urandom(),
               $urandom_range(0, 2) != 0);
      end
      for (int i = 0; i < 3; i++) bstep(1'b1, $urandom(), 1'b0);
      do_reset();
      bstep(1'b0, 32'd0, 1'b1);
      idle(2, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/avalon_tx_fifo_port.md
# avalon_tx_fifo_port

Parametrised Avalon-MM slave that buffers CPU writes in a FIFO and drains them to a downstream transmitter (e.g. UART TX) over a valid/ready stream. It adds configurable data width and depth, fill-level status, a sticky overflow flag, a drain enable, flush, and a level-threshold interrupt. It sits between the system interconnect and a serial transmit engine in the controller subsystem.

## Interface
- DATA_W, 8, stream/entry width, 1..32
- DEPTH, 16, FIFO entries, power of two, 2..128
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data
- readdata  out  32  combinational read mux, zero-extended
- out_data  out  DATA_W  FIFO head entry; 0 when out_valid=0
- out_valid  out  1  head entry available
- out_ready  in  1  downstream accepts head when high with out_valid
- irq  out  1  level-sensitive interrupt

## Operation
- A write is `chipselect & ~write_n`. Reads have no side effects.
- Register map:
  - 0 DATA: write pushes `writedata[DATA_W-1:0]`. Read returns out_data.
  - 1 STATUS (read): [7:0] level, [8] empty, [9] full, [10] overflow. Writing bit 10 = 1 clears overflow. Other bits ignored.
  - 2 CONTROL: [0] enable (reset 1), [1] irq_en (reset 0), [2] flush (write-1 strobe, reads 0).
  - 3 THRESHOLD: [7:0] thr (reset 0).
- Storage is a flop array with rd_ptr/wr_ptr of log2(DEPTH) bits, wrapping modulo DEPTH, and a registered level counter, 0..DEPTH.
- `out_valid = enable & (level != 0)`. Pop = `out_valid & out_ready`. When enable=0, entries are retained.
- Push accepted = DATA write & (level < DEPTH, or pop in the same cycle).
- A rejected push is dropped and sets overflow (sticky until cleared by W1C or reset).
- Level update: +1 on push only, -1 on pop only, unchanged on both.
- Flush:
  - Sets pointers and level to 0 next cycle.
  - Overrides a same-cycle push (discarded, overflow not set) and a same-cycle pop.
- `irq = irq_en & (level <= thr)`, registered. Intended use is a "space available / low water" interrupt.
- Writes to unused bits have no effect. Readdata bits above the defined fields read 0.
- Reset values: readdata follows the mux; out_valid 0, out_data 0, irq 0, level 0, overflow 0, enable 1, irq_en 0, thr 0. Memory contents are not reset.

## Timing
- Push to out_valid: 1 cycle. An entry written at edge N is visible after edge N, with no same-cycle bypass.
- Pop: the head advances at the edge where out_valid & out_ready. The next entry is presented in the same cycle after that edge, so back-to-back pops sustain 1 entry/cycle.
- STATUS reflects pushes/pops from the previous edge; readdata is combinational on address.
- irq lags level/thr/irq_en changes by 1 cycle.
- Full boundary: a push at level = DEPTH with no pop drops the data and sets overflow at that edge. A push at level = DEPTH with a pop is accepted and level stays DEPTH.
- Empty boundary: at level 0, out_valid = 0 and out_ready is ignored (no underflow).
- Wrap: pointers wrap DEPTH-1 → 0 with no gap or duplicate.
- An overflow W1C and a new overflow in the same cycle: set wins.
- reset_n low at any time asynchronously clears all state. Entries in flight are lost and out_valid falls immediately.

## Test plan
- Reset, then write 0x41, 0x42, 0x43 to DATA with out_ready=1 → out_data 0x41, 0x42, 0x43 on consecutive cycles starting 1 cycle after the first write; level returns to 0; STATUS = 0x100.
- DEPTH=16, out_ready=0, 17 writes → STATUS reads 0x210 (level 16, full). After the 17th write, overflow is set (0x610). Draining yields the first 16 values in order. Writing 0x400 to STATUS clears overflow.
- Full FIFO, out_ready=1 while writing 0x5A every cycle → no overflow, level stays 16, and 0x5A is delivered in order after the older entries.
- CONTROL=0 with 3 entries → out_valid=0, level holds at 3. CONTROL=1 → the 3 entries drain. Then 5 entries plus CONTROL=0x5 (flush) → level 0 next cycle, out_valid=0.
- THRESHOLD=2, CONTROL=3, level goes 0→4→2 → irq 1 at level 0, 0 at level 4, 1 at level 2, each change one cycle after the level change.
- DATA_W=12, DEPTH=4: write 0xFFFABC → out_data 0xABC. Run 10 push/pop cycles to exercise pointer wrap with correct ordering. Assert reset_n mid-stream → out_valid, level and irq are 0 immediately.
